// File: rtl/pcpi_arbiter.sv
// pcpi_arbiter: shares the core's single PCPI port between NUM_SLAVES
// coprocessors. Each instruction goes to every slave. The lowest-index
// slave that claims it (wait or ready) becomes the owner, and the owner's
// handshake is routed back to the core. If no slave claims the instruction
// within TIMEOUT_CYCLES, a one-cycle timeout pulse lets the core trap it as
// illegal.
module pcpi_arbiter #(
    parameter int NUM_SLAVES     = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    // core side
    input  logic                     pcpi_valid,
    input  logic [31:0]              pcpi_insn,
    input  logic [31:0]              pcpi_rs1,
    input  logic [31:0]              pcpi_rs2,
    output logic                     pcpi_wr,
    output logic [31:0]              pcpi_rd,
    output logic                     pcpi_wait,
    output logic                     pcpi_ready,
    output logic                     pcpi_timeout,
    output logic                     err_multi,
    // slave side
    output logic [NUM_SLAVES-1:0]    s_valid,
    output logic [31:0]              s_insn,
    output logic [31:0]              s_rs1,
    output logic [31:0]              s_rs2,
    input  logic [NUM_SLAVES-1:0]    s_wait,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    input  logic [NUM_SLAVES-1:0]    s_wr,
    input  logic [32*NUM_SLAVES-1:0] s_rd
);

    localparam int OW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, PROBE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;

    logic [NUM_SLAVES-1:0] sv_c, claim_c;
    logic                  wait_c, ready_c, wr_c, tmo_c, multi_c;
    logic [31:0]           rd_c;
    int                    win_c;

    // State, owner and timeout counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            owner_q <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Next-state logic and combinational routing of the selected slave
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        tcnt_d  = tcnt_q;
        sv_c    = '0;
        claim_c = '0;
        win_c   = 0;
        wait_c  = 1'b0;
        ready_c = 1'b0;
        wr_c    = 1'b0;
        rd_c    = '0;
        tmo_c   = 1'b0;
        multi_c = 1'b0;
        case (state_q)
            IDLE, PROBE: begin
                sv_c    = {NUM_SLAVES{pcpi_valid}};
                claim_c = (s_wait | s_ready) & sv_c;
                // Clearing the lowest set bit leaves a nonzero value only
                // when two or more slaves claim.
                multi_c = |(claim_c & (claim_c - NUM_SLAVES'(1)));
                for (int i = NUM_SLAVES - 1; i >= 0; i--)
                    if (claim_c[i]) win_c = i;
                if (!pcpi_valid) begin
                    state_d = IDLE;
                    tcnt_d  = '0;
                    owner_d = '0;
                end else if (|claim_c) begin
                    if (s_ready[win_c]) begin
                        // Zero-latency result: the winner already has it.
                        ready_c = 1'b1;
                        wr_c    = s_wr[win_c];
                        rd_c    = s_rd[32*win_c +: 32];
                        state_d = DONE;
                    end else begin
                        wait_c  = 1'b1;
                        owner_d = OW'(win_c);
                        state_d = BUSY;
                    end
                end else if (state_q == IDLE) begin
                    state_d = PROBE;
                end else if (tcnt_q == TLAST) begin
                    tmo_c   = 1'b1;
                    state_d = DONE;
                end else if (tcnt_q < TMAX) begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            BUSY: begin
                sv_c[owner_q] = pcpi_valid;
                if (!pcpi_valid) begin
                    // Core abort: drop the transaction and return no result.
                    state_d = IDLE;
                    tcnt_d  = '0;
                    owner_d = '0;
                end else if (s_ready[owner_q]) begin
                    ready_c = 1'b1;
                    wr_c    = s_wr[owner_q];
                    rd_c    = s_rd[32*owner_q +: 32];
                    state_d = DONE;
                end else begin
                    wait_c = s_wait[owner_q];
                end
            end
            DONE: begin
                if (!pcpi_valid) begin
                    state_d = IDLE;
                    tcnt_d  = '0;
                    owner_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output is forced low while resetn is asserted
    assign pcpi_wait    = resetn & wait_c;
    assign pcpi_ready   = resetn & ready_c;
    assign pcpi_wr      = resetn & wr_c;
    assign pcpi_rd      = resetn ? rd_c : 32'h0;
    assign pcpi_timeout = resetn & tmo_c;
    assign err_multi    = resetn & multi_c;
    assign s_valid      = sv_c & {NUM_SLAVES{resetn}};
    assign s_insn       = resetn ? pcpi_insn : 32'h0;
    assign s_rs1        = resetn ? pcpi_rs1  : 32'h0;
    assign s_rs2        = resetn ? pcpi_rs2  : 32'h0;

endmodule

// File: doc/pcpi_arbiter.md
Name: pcpi_arbiter

Overview:
- Shares the core's single PCPI port between NUM_SLAVES coprocessors, e.g. slave 0 = internal MUL unit, slave 1 = DIV unit, slave 2 = external PCPI.
- Broadcasts each instruction to all slaves and locks onto the first slave that claims it.
- Routes that slave's wait/ready/wr/rd back to the core.
- Raises a timeout when no slave claims the instruction, so the core can trap it as illegal.

Parameters:
NUM_SLAVES, 3, number of coprocessor slaves (1..8); lower index = higher priority
TIMEOUT_CYCLES, 16, number of unclaimed cycles before pcpi_timeout fires (2..255)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
pcpi_valid  in  1  core: instruction offered
pcpi_insn  in  32  core: instruction word, broadcast
pcpi_rs1  in  32  core: operand 1, broadcast
pcpi_rs2  in  32  core: operand 2, broadcast
pcpi_wr  out  1  core: result write enable
pcpi_rd  out  32  core: result
pcpi_wait  out  1  core: instruction claimed, busy
pcpi_ready  out  1  core: result valid, single cycle
pcpi_timeout  out  1  core: one-cycle pulse, instruction unclaimed
err_multi  out  1  one-cycle pulse when two or more slaves claim in the same cycle
s_valid  out  NUM_SLAVES  per-slave gated valid
s_insn, s_rs1, s_rs2  out  32 each  broadcast copies of pcpi_insn/rs1/rs2
s_wait  in  NUM_SLAVES  per-slave wait
s_ready  in  NUM_SLAVES  per-slave ready
s_wr  in  NUM_SLAVES  per-slave write enable
s_rd  in  32*NUM_SLAVES  per-slave result; slave i drives bits [32i+31:32i]

Behaviour:
- Reset is asynchronous and active-low on resetn; the clock is clk.
- While resetn is low, every output is 0, state = IDLE, owner = 0, tcnt = 0.
- All core-facing outputs are additionally gated with resetn.
- States (registered):
  - IDLE: no instruction.
  - PROBE: instruction broadcast, not yet claimed.
  - BUSY: owner latched, owner holds wait.
  - DONE: result or timeout delivered; waiting for pcpi_valid to drop.
- s_valid[i]:
  - IDLE and PROBE: s_valid[i] = pcpi_valid.
  - BUSY: s_valid[i] = pcpi_valid & (i == owner).
  - DONE: s_valid[i] = 0.
- A claim is s_wait[i] | s_ready[i] while slave i's s_valid[i] is high. The winner is the lowest claiming index.
- err_multi pulses in any IDLE or PROBE cycle where more than one slave claims.
- IDLE or PROBE, with pcpi_valid high:
  - Winner asserts ready: pcpi_ready = 1, pcpi_wr = s_wr[w], pcpi_rd = s_rd[w], combinationally in that cycle (zero latency). Next state is DONE.
  - Winner asserts only wait: owner <= w, next state is BUSY. pcpi_wait = 1 in the same cycle.
  - No claim: IDLE moves to PROBE; PROBE increments tcnt.
  - tcnt reaches TIMEOUT_CYCLES-1 with no claim: pcpi_timeout = 1 for that cycle, next state is DONE.
- BUSY:
  - pcpi_wait = s_wait[owner].
  - s_ready[owner] passes through as pcpi_ready/wr/rd, then next state is DONE.
  - Ready and wait asserted together by the owner: ready takes precedence.
  - Other slaves' signals are ignored.
- DONE: all core outputs are 0. When pcpi_valid = 0, next state is IDLE and tcnt clears.
- pcpi_valid dropping in PROBE or BUSY is a core abort: next state is IDLE, tcnt and owner clear, no ready or timeout is produced.
- pcpi_rd = 0 and pcpi_wr = 0 whenever pcpi_ready = 0.
- pcpi_ready and pcpi_timeout are mutually exclusive.
- pcpi_wait is never high in the same cycle as pcpi_ready.
- A ready arriving in the same cycle the timeout would fire wins; no timeout is raised.
- tcnt is sized to hold TIMEOUT_CYCLES, saturates, and never wraps.

Test Plan:
- Reset with s_wait = 3'b111 forced high -> all outputs 0; first cycle after release with pcpi_valid = 0 -> s_valid = 0, pcpi_wait = 0.
- MUL insn 0x02B50533, slave0 waits 33 cycles then returns ready with s_wr = 1, s_rd = 0x0000_0C35 -> pcpi_wait high for 33 cycles; pcpi_ready pulses 1 cycle with pcpi_rd = 0x00000C35 and pcpi_wr = 1; during BUSY s_valid = 3'b001.
- Slaves 1 and 2 claim with wait in the same cycle -> owner = 1, err_multi pulses once, s_valid = 3'b010 from the next cycle.
- No slave responds -> pcpi_timeout pulses on cycle 16 after pcpi_valid rises, no ready; s_valid stays 0 until pcpi_valid drops and is re-raised.
- Slave2 gives single-cycle ready with s_rd = 0xDEADBEEF, s_wr = 0 -> same-cycle pcpi_ready = 1, pcpi_rd = 0xDEADBEEF, pcpi_wr = 0.
- Abort and reset mid-op:
  - pcpi_valid drops in BUSY -> IDLE next cycle, no ready; a new instruction is probed normally.
  - resetn asserted in BUSY -> all outputs 0 immediately.
